// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Each bit is decided by a 3-sample majority vote around its centre. The stop bit is checked,
// and received words sit in a valid/ready holding register that flags overruns.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits. Otherwise parity_err is 0.

module uart_rx_param #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rx_s, rx_dly_q, rx_fall;
    logic [DIV_W-1:0]     tcnt_q, tcnt_d, div_q, div_d, half;
    logic                 at_s0, at_s1, at_vote, at_wrap;
    logic                 s0_q, s0_d, s1_q, s1_d, vote;
    logic [CntW-1:0]      bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_frm_q, perr_frm_d;   // parity result of the frame in flight
    logic                 stop_vote;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;

`ifdef UART_RX_PARITY_EN
    logic                 par_odd_q, par_odd_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Two-flop synchroniser plus a delayed copy for falling-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            rx_dly_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], rx};
            rx_dly_q <= sync_q[1];
        end
    end

    assign rx_s    = sync_q[1];
    assign rx_fall = rx_dly_q & ~rx_s;

    assign half    = div_q >> 1;
    assign at_s0   = (tcnt_q == half - DIV_W'(1));
    assign at_s1   = (tcnt_q == half);
    assign at_vote = (tcnt_q == half + DIV_W'(1));
    assign at_wrap = (tcnt_q == div_q - DIV_W'(1));
    assign vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    // Next-state, bit timer, sampling and holding-register logic
    always_comb begin
        state_d    = state_q;
        tcnt_d     = at_wrap ? '0 : tcnt_q + DIV_W'(1);
        div_d      = div_q;
        s0_d       = at_s0 ? rx_s : s0_q;
        s1_d       = at_s1 ? rx_s : s1_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        perr_frm_d = perr_frm_q;
        stop_vote  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_odd_d  = par_odd_q;
`endif
        valid_d    = valid_q;
        data_d     = data_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        ovr_d      = 1'b0;

        case (state_q)
            StIdle: begin
                tcnt_d = '0;
                if (rx_fall) begin
                    div_d      = baud_div;
                    bcnt_d     = '0;
                    perr_frm_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_odd_d  = parity_odd;
`endif
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (at_vote) begin
                    state_d = vote ? StIdle : StData;
                end
            end
            StData: begin
                if (at_vote) begin
                    // LSB arrives first, so shifting in at the top leaves it at bit 0
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + CntW'(1);
                    if (bcnt_q == CntW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_vote) begin
                    perr_frm_d = ((^shreg_q) ^ vote) != par_odd_q;
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (at_vote) begin
                    stop_vote = 1'b1;
                    // Back to idle mid stop bit so a following start edge is not missed
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (stop_vote) begin
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                data_d  = shreg_q;
                ferr_d  = ~vote;
                perr_d  = perr_frm_q;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tcnt_q     <= '0;
            div_q      <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            perr_frm_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_odd_q  <= 1'b0;
`endif
            valid_q    <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            div_q      <= div_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            perr_frm_q <= perr_frm_d;
`ifdef UART_RX_PARITY_EN
            par_odd_q  <= par_odd_d;
`endif
            valid_q    <= valid_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_valid    = valid_q;
    assign rx_data     = data_q;
    assign frame_err   = ferr_q;
    assign parity_err  = perr_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param. Each frame it sends becomes an expected event: a busy window plus,
// for a complete frame, the completion cycle and the resulting word and flags. The times
// come from the bit timing (edge detect delay, bit periods, stop-bit vote). A per-cycle
// compare process steps a small output-register model from those events.
`timescale 1ns/1ps

module tb_uart_rx_param;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned DIV_W     = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 rx = 1'b1;
    logic [DIV_W-1:0]     baud_div = 16'd16;
    logic                 parity_odd = 1'b0;
    logic                 rx_ready = 1'b1;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 frame_err, parity_err, overrun_err, busy;

    uart_rx_param #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .baud_div    (baud_div),
        .parity_odd  (parity_odd),
        .rx_ready    (rx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       fs;        // first cycle busy is expected high
        int       fe;        // cycle the frame ends (busy low; word lands if is_frame)
        bit       is_frame;
        logic [7:0] data;
        bit       ferr;
        bit       perr;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         pass_cnt = 0;
    int         total = 0;

    // Output-register model
    bit         m_valid, m_ferr, m_perr, m_ovr, m_busy;
    logic [7:0] m_data;

    // Observations for literal checks
    logic [7:0] got_data[$];
    bit         got_ferr[$];
    bit         got_perr[$];
    int         ovr_seen = 0;
    int         busy_cnt = 0;
    int         busy_rise = -1;
    int         first_rise = -1;
    int         last_f = 0;
    bit         prev_valid = 1'b0, prev_busy = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
    logic [7:0] prev_data = '0;
    bit         rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    endtask

    // Per-cycle model step and comparison
    initial begin
        forever begin
            bit ev_frame;
            @(posedge clk);
            cyc++;
            rdy = rx_ready;
            m_ovr = 1'b0;
            if (rst) begin
                m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_perr = 1'b0; m_busy = 1'b0;
                evq.delete();
            end else begin
                if (prev_valid && rdy) begin
                    got_data.push_back(prev_data);
                    got_ferr.push_back(prev_ferr);
                    got_perr.push_back(prev_perr);
                end
                ev_frame = 1'b0;
                if (evq.size() > 0 && cyc == evq[0].fe) begin
                    if (evq[0].is_frame) begin
                        ev_frame = 1'b1;
                        if (!m_valid || rdy) begin
                            m_valid = 1'b1;
                            m_data  = evq[0].data;
                            m_ferr  = evq[0].ferr;
                            m_perr  = evq[0].perr;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end
                    evq.pop_front();
                end
                if (!ev_frame && m_valid && rdy) m_valid = 1'b0;
                m_busy = (evq.size() > 0) && (cyc >= evq[0].fs) && (cyc < evq[0].fe);
            end
            #1;
            chk("rx_valid", rx_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("overrun_err", overrun_err, m_ovr);
            if (m_valid || rst) begin
                chk("rx_data", rx_data, m_data);
                chk("frame_err", frame_err, m_ferr);
                chk("parity_err", parity_err, m_perr);
            end
            if (rx_valid && !prev_valid && first_rise < 0) first_rise = cyc;
            if (busy && !prev_busy) busy_rise = cyc;
            if (busy) busy_cnt++;
            if (overrun_err) ovr_seen++;
            prev_valid = rx_valid;
            prev_busy  = busy;
            prev_data  = rx_data;
            prev_ferr  = frame_err;
            prev_perr  = parity_err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; baud_div and parity_odd are disturbed mid-frame and restored at the stop bit
    task automatic send_frame(input logic [7:0] data, input int div, input bit stop_bit,
                              input bit par_bit, input bit glitch);
        bit  bits[$];
        int  half;
        ev_t e;
        half = div / 2;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (PB != 0) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (j == 0 && c == 0) begin
                    baud_div = DIV_W'(div);
                    last_f   = cyc + 1;
                    e.fs       = last_f + 2;
                    e.fe       = last_f + (DATA_BITS + 1 + PB) * div + half + 4;
                    e.is_frame = 1'b1;
                    e.data     = data;
                    e.ferr     = ~stop_bit;
                    e.perr     = (PB != 0) && (((^data) ^ par_bit) != parity_odd);
                    evq.push_back(e);
                end
                if (j == 2 && c == 0) begin
                    baud_div   = DIV_W'(div + 5);
                    parity_odd = ~parity_odd;
                end
                if (j == bits.size() - 1 && c == 0) begin
                    baud_div   = DIV_W'(div);
                    parity_odd = ~parity_odd;
                end
                rx = (glitch && c == half + 1) ? ~bits[j] : bits[j];
            end
        end
    endtask

    task automatic expect_word(input string name, input int idx, input logic [7:0] d,
                               input bit fe, input bit pe);
        chk({name, "_count"}, got_data.size() > idx, 1);
        if (got_data.size() > idx) begin
            chk({name, "_data"}, got_data[idx], d);
            chk({name, "_ferr"}, got_ferr[idx], fe);
            chk({name, "_perr"}, got_perr[idx], pe);
        end
    endtask

    initial begin
        ev_t e;
        int  f;
        #2 rst = 1'b1;
        idle(4);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_parity_err", parity_err, 0);
        chk("reset_overrun_err", overrun_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        idle(5);

        // Basic receive at 16 cycles/bit; all test bytes have even weight so parity bit is 0
        got_data.delete(); got_ferr.delete(); got_perr.delete();
        send_frame(8'h55, 16, 1'b1, 1'b0, 1'b0);
        f = last_f;
        send_frame(8'hA3, 16, 1'b1, 1'b0, 1'b0);
        idle(40);
        chk("first_valid_latency", first_rise - f, (PB != 0) ? 172 : 156);
        expect_word("basic0", 0, 8'h55, 1'b0, 1'b0);
        expect_word("basic1", 1, 8'hA3, 1'b0, 1'b0);

        // False start: 4 low cycles
        got_data.delete(); got_ferr.delete(); got_perr.delete();
        busy_cnt = 0;
        @(negedge clk);
        rx = 1'b0;
        f = cyc + 1;
        e.fs = f + 2; e.fe = f + 12; e.is_frame = 1'b0;
        e.data = '0; e.ferr = 1'b0; e.perr = 1'b0;
        evq.push_back(e);
        idle(3);
        @(negedge clk) rx = 1'b1;
        idle(40);
        chk("false_start_busy_cycles", busy_cnt, 10);
        chk("false_start_busy_delay", busy_rise - f, 2);
        chk("false_start_no_word", got_data.size(), 0);

        // Glitch tolerance, then a low stop bit, at 32 cycles/bit
        got_data.delete(); got_ferr.delete(); got_perr.delete();
        send_frame(8'h3C, 32, 1'b1, 1'b0, 1'b1);
        idle(20);
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rx = 1'b1;
        idle(60);
        expect_word("glitch", 0, 8'h3C, 1'b0, 1'b0);
        expect_word("frame_err", 1, 8'h3C, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong
        got_data.delete(); got_ferr.delete(); got_perr.delete();
        parity_odd = 1'b0;
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0);
        send_frame(8'h07, 16, 1'b1, 1'b0, 1'b0);
        idle(40);
        expect_word("parity_ok", 0, 8'h07, 1'b0, 1'b0);
        expect_word("parity_bad", 1, 8'h07, 1'b0, 1'b1);
`endif

        // Overrun: consumer stalled across two back-to-back frames
        got_data.delete(); got_ferr.delete(); got_perr.delete();
        ovr_seen = 0;
        rx_ready = 1'b0;
        send_frame(8'h11, 16, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 16, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("overrun_held_valid", rx_valid, 1);
        chk("overrun_held_data", rx_data, 8'h11);
        chk("overrun_pulse_cycles", ovr_seen, 1);
        @(negedge clk) rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
        idle(3);
        chk("overrun_drained", rx_valid, 0);
        expect_word("overrun_accept", 0, 8'h11, 1'b0, 1'b0);
        chk("overrun_one_word", got_data.size(), 1);

        // Reset mid-frame with a word still held
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0);
        idle(30);
        @(negedge clk);
        rx = 1'b0;
        f = cyc + 1;
        e.fs = f + 2; e.fe = f + 1000000; e.is_frame = 1'b0;
        e.data = '0; e.ferr = 1'b0; e.perr = 1'b0;
        evq.push_back(e);
        idle(15);
        @(negedge clk) rx = 1'b1;
        idle(63);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("midreset_rx_valid", rx_valid, 0);
        chk("midreset_rx_data", rx_data, 0);
        chk("midreset_frame_err", frame_err, 0);
        chk("midreset_parity_err", parity_err, 0);
        chk("midreset_overrun_err", overrun_err, 0);
        chk("midreset_busy", busy, 0);
        idle(3);
        rst = 1'b0;
        rx_ready = 1'b1;
        idle(10);
        got_data.delete(); got_ferr.delete(); got_perr.delete();
        send_frame(8'h81, 16, 1'b1, 1'b0, 1'b0);
        idle(30);
        expect_word("after_reset", 0, 8'h81, 1'b0, 1'b0);

        idle(5);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total);
        $fatal(1, "watchdog");
    end

endmodule
